// File: rtl/cpu64_fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer with registered head,
// skid-reserving stall, sticky overflow and flush on redirect.
module cpu64_fetch_queue #(
   parameter int unsigned VADDR = 39,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned SKID  = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       enq_valid_i,
   input  logic [VADDR-1:0]           enq_pc_i,
   input  logic [VADDR-1:0]           enq_next_pc_i,
   input  logic [31:0]                enq_instr_i,
   input  logic                       enq_is16_i,
   output logic                       stall_o,
   output logic                       deq_valid_o,
   input  logic                       deq_ready_i,
   output logic [VADDR-1:0]           deq_pc_o,
   output logic [VADDR-1:0]           deq_next_pc_o,
   output logic [31:0]                deq_instr_o,
   output logic                       deq_is16_o,
   output logic                       deq_len_err_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] LP_FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] LP_STALL = CW'(DEPTH - SKID);

   logic [VADDR-1:0] r_pc    [DEPTH];
   logic [VADDR-1:0] r_npc   [DEPTH];
   logic [31:0]      r_instr [DEPTH];
   logic             r_is16  [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;

   logic w_valid;
   logic w_full;
   logic w_deq_fire;
   logic w_enq_fire;
   logic w_drop;

   always_comb begin
      w_valid    = (r_count != '0);
      w_full     = (r_count == LP_FULL);
      w_deq_fire = w_valid && deq_ready_i && !flush_i;
      // A full queue still accepts when the head leaves the same cycle.
      w_enq_fire = enq_valid_i && !flush_i && (!w_full || w_deq_fire);
      w_drop     = enq_valid_i && !flush_i && w_full && !w_deq_fire;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (flush_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_enq_fire) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_deq_fire) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_enq_fire && !w_deq_fire)      r_count <= r_count + CW'(1);
         else if (!w_enq_fire && w_deq_fire) r_count <= r_count - CW'(1);
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_pc[i]    <= '0;
            r_npc[i]   <= '0;
            r_instr[i] <= '0;
            r_is16[i]  <= 1'b0;
         end
      end else if (w_enq_fire) begin
         r_pc[r_wr_ptr]    <= enq_pc_i;
         r_npc[r_wr_ptr]   <= enq_next_pc_i;
         r_instr[r_wr_ptr] <= enq_instr_i;
         r_is16[r_wr_ptr]  <= enq_is16_i;
      end
   end

   always_comb begin
      deq_valid_o   = w_valid;
      deq_pc_o      = r_pc[r_rd_ptr];
      deq_next_pc_o = r_npc[r_rd_ptr];
      deq_is16_o    = r_is16[r_rd_ptr];
      deq_instr_o   = r_is16[r_rd_ptr] ? {16'h0000, r_instr[r_rd_ptr][15:0]}
                                       : r_instr[r_rd_ptr];
      // Length encoding disagrees with the fetch-side compressed flag.
      deq_len_err_o = w_valid &&
                      (r_is16[r_rd_ptr] == (r_instr[r_rd_ptr][1:0] == 2'b11));
      stall_o       = (r_count >= LP_STALL);
      count_o       = r_count;
      overflow_o    = r_overflow;
   end

endmodule

// File: tb/tb_cpu64_fetch_queue.sv
// Self-checking bench for cpu64_fetch_queue: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_cpu64_fetch_queue;

   localparam int unsigned VADDR = 39;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned SKID  = 2;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             flush_i;
   logic             enq_valid_i;
   logic [VADDR-1:0] enq_pc_i;
   logic [VADDR-1:0] enq_next_pc_i;
   logic [31:0]      enq_instr_i;
   logic             enq_is16_i;
   logic             stall_o;
   logic             deq_valid_o;
   logic             deq_ready_i;
   logic [VADDR-1:0] deq_pc_o;
   logic [VADDR-1:0] deq_next_pc_o;
   logic [31:0]      deq_instr_o;
   logic             deq_is16_o;
   logic             deq_len_err_o;
   logic [2:0]       count_o;
   logic             overflow_o;

   cpu64_fetch_queue #(.VADDR(VADDR), .DEPTH(DEPTH), .SKID(SKID)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .enq_valid_i(enq_valid_i), .enq_pc_i(enq_pc_i), .enq_next_pc_i(enq_next_pc_i),
      .enq_instr_i(enq_instr_i), .enq_is16_i(enq_is16_i), .stall_o(stall_o),
      .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i), .deq_pc_o(deq_pc_o),
      .deq_next_pc_o(deq_next_pc_o), .deq_instr_o(deq_instr_o),
      .deq_is16_o(deq_is16_o), .deq_len_err_o(deq_len_err_o),
      .count_o(count_o), .overflow_o(overflow_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [VADDR-1:0] pc;
      logic [VADDR-1:0] npc;
      logic [31:0]      instr;
      logic             is16;
   } ent_t;

   typedef struct {
      logic             fl;
      logic             ev;
      logic             rdy;
      logic [VADDR-1:0] pc;
      logic             e_v;
      logic [VADDR-1:0] e_pc;
      int unsigned      e_cnt;
      logic             e_st;
      logic             e_ov;
   } vec_t;

   ent_t mq[$];
   logic m_ovf;
   int   n_vec;
   int   n_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic fl, input logic ev, input logic rdy,
                             input ent_t e);
      bit deq, full;
      if (fl) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         deq  = (mq.size() != 0) && rdy;
         full = (mq.size() == DEPTH);
         if (deq) void'(mq.pop_front());
         if (ev) begin
            if (!full || deq) mq.push_back(e);
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic check_model();
      ent_t h;
      logic [31:0] xi;
      chk("valid", 64'(deq_valid_o), 64'(mq.size() != 0));
      chk("count", 64'(count_o), 64'(mq.size()));
      chk("stall", 64'(stall_o), 64'(mq.size() >= DEPTH - SKID));
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
      if (mq.size() != 0) begin
         h  = mq[0];
         xi = h.is16 ? {16'h0000, h.instr[15:0]} : h.instr;
         chk("pc", 64'(deq_pc_o), 64'(h.pc));
         chk("next_pc", 64'(deq_next_pc_o), 64'(h.npc));
         chk("instr", 64'(deq_instr_o), 64'(xi));
         chk("is16", 64'(deq_is16_o), 64'(h.is16));
         chk("len_err", 64'(deq_len_err_o),
             64'(h.is16 ? (h.instr[1:0] == 2'b11) : (h.instr[1:0] != 2'b11)));
      end else begin
         chk("len_err_idle", 64'(deq_len_err_o), 64'd0);
      end
   endtask

   // Drive one cycle of inputs, step the model across the edge, check outputs.
   task automatic cyc(input logic fl, input logic ev, input logic rdy,
                      input logic [VADDR-1:0] pc, input logic [31:0] ins,
                      input logic is16);
      ent_t e;
      e.pc = pc; e.npc = pc + 39'd4; e.instr = ins; e.is16 = is16;
      flush_i       = fl;
      enq_valid_i   = ev;
      deq_ready_i   = rdy;
      enq_pc_i      = e.pc;
      enq_next_pc_i = e.npc;
      enq_instr_i   = ins;
      enq_is16_i    = is16;
      @(posedge clk_i);
      #1;
      model_step(fl, ev, rdy, e);
      check_model();
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, '0, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      flush_i = 1'b0; enq_valid_i = 1'b0; deq_ready_i = 1'b0;
      enq_pc_i = '0; enq_next_pc_i = '0; enq_instr_i = '0; enq_is16_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      mq.delete();
      m_ovf = 1'b0;
   endtask

   vec_t tbl[12];

   initial begin
      n_vec = 0;
      n_err = 0;
      m_ovf = 1'b0;

      //            fl    ev    rdy   pc       e_v   e_pc     cnt st    ov
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 39'h100, 1'b1, 39'h100, 1, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 39'h0,   1'b0, 39'h0,   0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 39'h0,   1'b1, 39'h0,   1, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 39'h4,   1'b1, 39'h0,   2, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 39'h8,   1'b1, 39'h0,   3, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 39'hC,   1'b1, 39'h0,   4, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 39'h14,  1'b1, 39'h0,   4, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 39'h0,   1'b1, 39'h4,   3, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 39'h0,   1'b1, 39'h8,   2, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 39'h0,   1'b1, 39'hC,   1, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 39'h0,   1'b0, 39'h0,   0, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 39'h0,   1'b0, 39'h0,   0, 1'b0, 1'b0};

      do_reset();
      #1;
      chk("rst_valid", 64'(deq_valid_o), 64'd0);
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_stall", 64'(stall_o), 64'd0);
      chk("rst_ovf", 64'(overflow_o), 64'd0);
      chk("rst_len_err", 64'(deq_len_err_o), 64'd0);

      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].fl, tbl[i].ev, tbl[i].rdy, tbl[i].pc, 32'h00000013, 1'b0);
         chk($sformatf("tbl%0d_valid", i), 64'(deq_valid_o), 64'(tbl[i].e_v));
         chk($sformatf("tbl%0d_count", i), 64'(count_o), 64'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_stall", i), 64'(stall_o), 64'(tbl[i].e_st));
         chk($sformatf("tbl%0d_ovf", i), 64'(overflow_o), 64'(tbl[i].e_ov));
         if (tbl[i].e_v) chk($sformatf("tbl%0d_pc", i), 64'(deq_pc_o), 64'(tbl[i].e_pc));
      end

      // Full queue: simultaneous enq/deq, then steady streaming across wrap.
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 39'(4 * i), 32'h00000013, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 39'h10, 32'h00000013, 1'b0);
      chk("full_swap_count", 64'(count_o), 64'd4);
      chk("full_swap_head", 64'(deq_pc_o), 64'h4);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 39'(39'h14 + 4 * i), 32'h00000013, 1'b0);
      chk("stream_ovf", 64'(overflow_o), 64'd0);
      chk("stream_head", 64'(deq_pc_o), 64'h2C);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, '0, 32'h0, 1'b0);

      // Compressed payload masking and length-error flag.
      cyc(1'b0, 1'b1, 1'b0, 39'h200, 32'hFFFF4501, 1'b1);
      chk("c16_instr", 64'(deq_instr_o), 64'h00004501);
      chk("c16_len_err", 64'(deq_len_err_o), 64'd0);
      cyc(1'b0, 1'b1, 1'b1, 39'h202, 32'h00000013, 1'b1);
      chk("bad16_len_err", 64'(deq_len_err_o), 64'd1);
      cyc(1'b0, 1'b0, 1'b1, '0, 32'h0, 1'b0);

      // Flush with 3 entries and overflow pending; flushed-cycle enqueue is lost.
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 39'(39'h300 + 4 * i), 32'h00000013, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, '0, 32'h0, 1'b0);
      chk("pre_flush_count", 64'(count_o), 64'd3);
      chk("pre_flush_ovf", 64'(overflow_o), 64'd1);
      cyc(1'b1, 1'b1, 1'b0, 39'h400, 32'h00000013, 1'b0);
      chk("flush_count", 64'(count_o), 64'd0);
      chk("flush_valid", 64'(deq_valid_o), 64'd0);
      chk("flush_ovf", 64'(overflow_o), 64'd0);
      chk("flush_stall", 64'(stall_o), 64'd0);
      idle();
      chk("post_flush_valid", 64'(deq_valid_o), 64'd0);

      // Asynchronous reset mid-cycle with two entries queued.
      cyc(1'b0, 1'b1, 1'b0, 39'h500, 32'h00000013, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 39'h504, 32'h00000013, 1'b0);
      flush_i = 1'b0; enq_valid_i = 1'b0; deq_ready_i = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_valid", 64'(deq_valid_o), 64'd0);
      chk("arst_count", 64'(count_o), 64'd0);
      chk("arst_stall", 64'(stall_o), 64'd0);
      chk("arst_ovf", 64'(overflow_o), 64'd0);
      do_reset();

      // Randomized traffic against the reference queue.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 99) < 4),
             ($urandom_range(0, 99) < 70),
             ($urandom_range(0, 99) < 55),
             {$urandom(), $urandom()} & {VADDR{1'b1}},
             $urandom(),
             $urandom_range(0, 1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete, got running expected finished");
      $fatal(1);
   end

endmodule
